// File: rtl/mrr_loopback_pop_client.sv
// mrr_loopback_pop_client
// Decode-chain-side requester for the per-node loopback queue. A fetch
// command requests the oldest queued message for one chip ID, holds the
// request until the queue acknowledges, latches the message and then
// serialises it MSB-first over a valid/ready bit stream.
//
// Optional feature: define MRR_LOOPBACK_POP_TIMEOUT_EN to abandon a request
// that is not acknowledged within POP_TIMEOUT_CYCLES clocks (timeout_err).
// With the macro undefined the request waits indefinitely and timeout_err
// is tied low.

module mrr_loopback_pop_client #(
    parameter int CHIP_ID_LEN          = 8,
    parameter int LOOPBACK_MESSAGE_LEN = 32,
    parameter int POP_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_req,
    input  logic [CHIP_ID_LEN-1:0]          fetch_chip_id,
    output logic [CHIP_ID_LEN-1:0]          pop_chip_id,
    output logic                            pop_request,
    input  logic                            pop_ack,
    input  logic [LOOPBACK_MESSAGE_LEN-1:0] pop_message,
    output logic                            bit_out,
    output logic                            bit_valid,
    input  logic                            bit_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            empty,
    output logic                            timeout_err
);

    localparam int MSG_W = LOOPBACK_MESSAGE_LEN;
    localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    // Elaboration-time sanity check of the configuration.
    if (CHIP_ID_LEN < 1 || MSG_W < 1 || POP_TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("mrr_loopback_pop_client: illegal parameter values");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [MSG_W-1:0]         shift_q, shift_d;
    logic [MSG_W-1:0]         shift_next;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CHIP_ID_LEN-1:0]   pop_chip_id_d;
    logic                     pop_request_d;
    logic                     bit_out_d;
    logic                     bit_valid_d;
    logic                     busy_d;
    logic                     done_d;
    logic                     empty_d;
    logic                     timeout_err_d;

`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
    localparam int TMO_W = $clog2(POP_TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pop_chip_id_d = pop_chip_id;
        pop_request_d = pop_request;
        bit_out_d     = bit_out;
        bit_valid_d   = bit_valid;
        done_d        = 1'b0;
        empty_d       = empty;
        timeout_err_d = timeout_err;
        shift_next    = shift_q << 1;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A stray pop_ack here is deliberately ignored.
                if (fetch_req) begin
                    pop_chip_id_d = fetch_chip_id;
                    empty_d       = 1'b0;
                    timeout_err_d = 1'b0;
                    pop_request_d = 1'b1;
                    state_d       = ST_REQUEST;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
                    tmo_cnt_d     = '0;
`endif
                end
            end

            ST_REQUEST: begin
                if (pop_ack) begin
                    // Drop the request on the ack edge so the queue never
                    // sees a lingering request once it is back in idle.
                    pop_request_d = 1'b0;
                    shift_d       = pop_message;
                    if (pop_message == '0) begin
                        empty_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d   = CNT_W'(MSG_W - 1);
                        bit_valid_d = 1'b1;
                        bit_out_d   = pop_message[MSG_W-1];
                        state_d     = ST_SHIFT;
                    end
                end
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
                // An ack in the expiry cycle takes priority over the timeout.
                else if (tmo_cnt_q == TMO_W'(POP_TIMEOUT_CYCLES - 1)) begin
                    pop_request_d = 1'b0;
                    timeout_err_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end

            ST_SHIFT: begin
                // bit_valid is high throughout SHIFT, so ready alone accepts.
                if (bit_ready) begin
                    shift_d   = shift_next;
                    bit_out_d = shift_next[MSG_W-1];
                    if (bit_cnt_q == '0) begin
                        bit_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pop_chip_id <= '0;
            pop_request <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            empty       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pop_chip_id <= pop_chip_id_d;
            pop_request <= pop_request_d;
            bit_out     <= bit_out_d;
            bit_valid   <= bit_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            empty       <= empty_d;
        end
    end

`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
    // Request timeout counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_err <= timeout_err_d;
        end
    end
`else
    // Without the timeout feature the error flag can never be raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
        end
    end

    logic unused_timeout;
    assign unused_timeout = timeout_err_d;
`endif

endmodule

// File: tb/tb_mrr_loopback_pop_client.sv
// Self-checking bench for mrr_loopback_pop_client: directed scenarios plus
// randomized fetches, checked against a message-level reference model.
`timescale 1ns/1ps

module tb_mrr_loopback_pop_client;

    localparam int CW = 8;
    localparam int ML = 32;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 1024;
`endif

    logic          clk;
    logic          rst;
    logic          fetch_req;
    logic [CW-1:0] fetch_chip_id;
    logic [CW-1:0] pop_chip_id;
    logic          pop_request;
    logic          pop_ack;
    logic [ML-1:0] pop_message;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          busy;
    logic          done;
    logic          empty;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    mrr_loopback_pop_client #(
        .CHIP_ID_LEN          (CW),
        .LOOPBACK_MESSAGE_LEN (ML),
        .POP_TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_chip_id (fetch_chip_id),
        .pop_chip_id   (pop_chip_id),
        .pop_request   (pop_request),
        .pop_ack       (pop_ack),
        .pop_message   (pop_message),
        .bit_out       (bit_out),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .busy          (busy),
        .done          (done),
        .empty         (empty),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (sampling/driving point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW+6:0] all_outs();
        return {pop_chip_id, pop_request, bit_out, bit_valid, busy, done, empty, timeout_err};
    endfunction

    // Issue a fetch from IDLE; one cycle later the request must be up.
    task automatic start_fetch(input logic [CW-1:0] chip);
        fetch_req     = 1'b1;
        fetch_chip_id = chip;
        tick();
        fetch_req     = 1'b0;
        fetch_chip_id = CW'($urandom);
        check("req_rise", pop_request, 1);
        check("req_chip", pop_chip_id, chip);
        check("busy_set", busy, 1);
        check("flags_clr", {empty, timeout_err}, 0);
    endtask

    // One complete fetch. mode: 0 ready always, 1 ready toggling, 2 random.
    // spam holds fetch_req high during the shift; abort_at >= 0 asserts an
    // asynchronous reset once that many bits have been accepted.
    task automatic do_fetch(input logic [CW-1:0] chip, input logic [ML-1:0] msg,
                            input int ack_delay, input int mode, input bit spam,
                            input int abort_at);
        int            bad = 0;
        int            n = 0;
        int            stable_bad = 0;
        int            stray = 0;
        logic [ML-1:0] got = '0;
        logic          pv = 1'b0;
        logic          pr = 1'b0;
        logic          pb = 1'b0;
        logic          r;

        start_fetch(chip);
        for (int i = 0; i < ack_delay; i++) begin
            if (pop_request !== 1'b1 || pop_chip_id !== chip) bad++;
            if (i == ack_delay - 1) begin
                pop_ack     = 1'b1;
                pop_message = msg;
            end
            tick();
        end
        pop_ack     = 1'b0;
        pop_message = ML'($urandom);
        check("req_held", bad, 0);
        check("req_drop", pop_request, 0);

        if (msg == '0) begin
            check("empty_set", empty, 1);
            check("empty_novalid", bit_valid, 0);
            check("empty_done", done, 1);
            tick();
            check("empty_done_1cyc", done, 0);
            check("empty_idle", busy, 0);
            check("empty_held", empty, 1);
            return;
        end

        check("first_valid", bit_valid, 1);
        for (int cyc = 0; cyc < ML * 40 && n < ML; cyc++) begin
            if (n == abort_at) begin
                bit_ready = 1'b0;
                fetch_req = 1'b0;
                #2 rst = 1'b1;
                #1 check("async_rst_outs", all_outs(), 0);
                tick();
                rst = 1'b0;
                tick();
                check("post_rst_idle", all_outs(), 0);
                return;
            end
            if (pv && !pr && bit_out !== pb) stable_bad++;
            if (done || pop_request || !bit_valid) stray++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bit_ready = r;
            if (spam) begin
                fetch_req     = 1'b1;
                fetch_chip_id = ~chip;
            end
            pv = bit_valid;
            pr = r;
            pb = bit_out;
            if (bit_valid && r) begin
                got[ML-1-n] = bit_out;
                n++;
            end
            tick();
        end
        fetch_req = 1'b0;
        bit_ready = 1'b0;

        check("bit_count", n, ML);
        check("bits", got, msg);
        check("hold_while_stalled", stable_bad, 0);
        check("shift_clean", stray, 0);
        check("done_pulse", done, 1);
        check("valid_drop", bit_valid, 0);
        check("chip_stable", pop_chip_id, chip);
        tick();
        check("done_1cyc", done, 0);
        check("back_idle", {busy, pop_request}, 0);
        check("no_flags", {empty, timeout_err}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        fetch_req     = 1'b0;
        fetch_chip_id = '0;
        pop_ack       = 1'b0;
        pop_message   = '0;
        bit_ready     = 1'b0;
        #1 check("reset_outs", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("idle_outs", all_outs(), 0);

        // Basic fetch with a slow queue and an always-ready sink.
        do_fetch(8'h12, 32'h8000_0001, 40, 0, 1'b0, -1);
        // Empty queue, then a fetch that must clear the sticky empty flag.
        do_fetch(8'h05, 32'h0, 3, 0, 1'b0, -1);
        // Toggling ready, with fetch_req hammered throughout the shift.
        do_fetch(8'h33, 32'hA5A5_A5A5, 5, 1, 1'b1, -1);

        // Stray acknowledge while idle must not start anything.
        pop_ack     = 1'b1;
        pop_message = 32'hDEAD_BEEF;
        tick();
        pop_ack = 1'b0;
        tick();
        check("stray_ack", {pop_request, bit_valid, busy, done}, 0);

        // Reset in the middle of the shift, then a clean fetch.
        do_fetch(8'h7E, 32'hF0F0_1234, 2, 0, 1'b0, 10);
        do_fetch(8'h7F, 32'h1357_9BDF, 1, 0, 1'b0, -1);

`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
        begin
            int held = 0;
            start_fetch(8'h44);
            for (int i = 0; i < TMO; i++) begin
                if (pop_request !== 1'b1) held++;
                tick();
            end
            check("tmo_req_held", held, 0);
            check("tmo_req_drop", pop_request, 0);
            check("tmo_err", timeout_err, 1);
            check("tmo_done", done, 1);
            tick();
            check("tmo_idle", {busy, done, timeout_err}, 3'b001);
        end
        // Ack in the final cycle before expiry wins over the timeout.
        do_fetch(8'h45, 32'h0000_00FF, TMO, 0, 1'b0, -1);
`else
        // No timeout: a very slow queue is simply waited for.
        do_fetch(8'h44, 32'hCAFE_F00D, 300, 0, 1'b0, -1);
`endif

        for (int k = 0; k < 20; k++) begin
            logic [ML-1:0] m;
            m = ($urandom_range(0, 4) == 0) ? '0 : ML'($urandom);
            do_fetch(CW'($urandom), m, $urandom_range(1, 40), 2,
                     1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
